// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller: FSM states,
// opcodes, aluop/ALU control codes and datapath mux select encodings.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps aluop plus funct3/funct7b5/op[5] to the
// 3-bit ALU control code.
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op[5] separates R-type sub from addi, whose imm bit 30 is data
          3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I datapath (lw, sw, R/I ALU, beq, jal).
// Define MULTICYCLE_CTRL_MEM_WAIT_EN to add mem_ready stalls in FETCH/MEMREAD/MEMWRITE.
module multicycle_controller
  import riscv_mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_ready;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_illegal;
  logic [1:0] w_aluop;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign w_mem_ready = mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    w_aluop     = ALUOP_ADD;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    case (r_state)
      S_FETCH: begin
        result_src = RES_ALURESULT;
        alu_src_b  = SRCB_FOUR;
        if (w_mem_ready) begin
          w_ir_write  = 1'b1;
          w_pc_update = 1'b1;
          w_next      = S_DECODE;
        end
      end
      S_DECODE: begin
        // PC+imm is computed here so beq can compare in a single later cycle
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (w_mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        if (w_mem_ready) w_next = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RD1;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RD1;
        w_aluop   = ALUOP_SUB;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_FOUR;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are gated by reset_n so nothing writes while the async reset is low
  assign pc_write   = reset_n & (w_pc_update | (w_branch & zero));
  assign ir_write   = reset_n & w_ir_write;
  assign mem_write  = reset_n & w_mem_write;
  assign reg_write  = reset_n & w_reg_write;
  assign illegal_op = reset_n & w_illegal;
  assign imm_src    = imm_src_of(op);
  assign state_o    = STATE_W'(r_state);

  alu_decoder u_alu_decoder (
    .aluop       (w_aluop),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule
